// File: rtl/ram8_bank.sv
// RAM8 register file: eight words with one-hot write decode, an 8:1 read mux,
// per-word valid flags and a sequenced bulk-clear engine.

module ram8_word #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             v
);
  // Clear takes priority, although the decoder never asserts we and clr together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
      v <= 1'b0;
    end else if (clr) begin
      q <= '0;
      v <= 1'b0;
    end else if (we) begin
      q <= d;
      v <= 1'b1;
    end
  end
endmodule

module ram8_bank #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  input  logic [2:0]       address,
  input  logic             clear,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic [7:0]       valid
);
  localparam int NUM_WORDS = 8;

  typedef enum logic {IDLE, CLEAR} state_t;

  typedef struct packed {
    logic             ld;
    logic [2:0]       addr;
    logic [WIDTH-1:0] data;
  } wr_req_t;

  state_t                            state, state_nxt;
  logic [2:0]                        ptr, ptr_nxt;
  logic [NUM_WORDS-1:0]              we_dec, clr_dec;
  logic [NUM_WORDS-1:0][WIDTH-1:0]   word;
  wr_req_t                           wreq;

  assign wreq = '{ld: load, addr: address, data: in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Clear beats a coincident load; loads and clears arriving while CLEAR runs are dropped.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    we_dec    = '0;
    clr_dec   = '0;
    case (state)
      IDLE: begin
        if (clear) begin
          state_nxt = CLEAR;
          ptr_nxt   = '0;
        end else if (wreq.ld) begin
          we_dec[wreq.addr] = 1'b1;
        end
      end
      CLEAR: begin
        clr_dec[ptr] = 1'b1;
        ptr_nxt      = ptr + 3'd1;
        if (ptr == 3'd7) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar i = 0; i < NUM_WORDS; i++) begin : g_word
    ram8_word #(.WIDTH(WIDTH)) u_word (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we_dec[i]),
      .clr   (clr_dec[i]),
      .d     (wreq.data),
      .q     (word[i]),
      .v     (valid[i])
    );
  end

  assign out  = word[address];
  assign busy = (state == CLEAR);
endmodule

// File: tb/tb_ram8_bank.sv
// Directed bench for ram8_bank: a vector table for write/read/clear/collision
// plus hand sequences for async reset and held clear.

module tb_ram8_bank;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;
  logic        clear;
  logic [15:0] out;
  logic        busy;
  logic [7:0]  valid;

  int errors = 0;
  int checks = 0;

  ram8_bank #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
    .load    (load),
    .address (address),
    .clear   (clear),
    .out     (out),
    .busy    (busy),
    .valid   (valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        cl;
    logic [2:0]  a;
    logic [15:0] d;
    logic [15:0] eo;
    logic [7:0]  ev;
    logic        eb;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic ld, logic cl, logic [2:0] a, logic [15:0] d,
                              logic [15:0] eo, logic [7:0] ev, logic eb);
    vec_t v;
    v.ld = ld; v.cl = cl; v.a = a; v.d = d; v.eo = eo; v.ev = ev; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill();
    for (int a = 0; a < 8; a++) begin
      load = 1'b1; address = 3'(a); in = 16'h1000 + 16'(a);
      tick();
    end
    load = 1'b0;
  endtask

  initial begin
    logic [7:0] m;
    logic       eb;

    // Vector table: each record is applied before an edge and checked just before that edge.
    for (int a = 0; a < 8; a++) begin
      m = (8'd1 << a) - 8'd1;
      tbl.push_back(mk(1'b1, 1'b0, 3'(a), 16'h1000 + 16'(a), 16'h0000, m, 1'b0));
    end
    for (int a = 0; a < 8; a++)
      tbl.push_back(mk(1'b0, 1'b0, 3'(a), 16'h0, 16'h1000 + 16'(a), 8'hFF, 1'b0));
    tbl.push_back(mk(1'b0, 1'b1, 3'd3, 16'h0, 16'h1003, 8'hFF, 1'b0));
    for (int k = 1; k <= 9; k++) begin
      m = 8'hFF << (k - 1);
      tbl.push_back(mk(1'b0, 1'b0, 3'd3, 16'h0, (k >= 5) ? 16'h0000 : 16'h1003, m, k <= 8));
    end
    tbl.push_back(mk(1'b1, 1'b0, 3'd5, 16'h5555, 16'h0000, 8'h00, 1'b0));
    tbl.push_back(mk(1'b1, 1'b1, 3'd5, 16'hBEEF, 16'h5555, 8'h20, 1'b0));
    for (int k = 1; k <= 8; k++)
      tbl.push_back(mk(1'b1, 1'b0, 3'd2, 16'h1234, 16'h0000, (k <= 6) ? 8'h20 : 8'h00, 1'b1));
    tbl.push_back(mk(1'b0, 1'b0, 3'd5, 16'h0, 16'h0000, 8'h00, 1'b0));
    tbl.push_back(mk(1'b0, 1'b0, 3'd2, 16'h0, 16'h0000, 8'h00, 1'b0));

    rst_n = 1'b0; in = '0; load = 1'b0; address = '0; clear = 1'b0;
    #12;
    chk("reset_out", 32'(out), 32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick();

    foreach (tbl[i]) begin
      load = tbl[i].ld; clear = tbl[i].cl; address = tbl[i].a; in = tbl[i].d;
      #1;
      chk($sformatf("vec%0d_out", i), 32'(out), 32'(tbl[i].eo));
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'(tbl[i].ev));
      chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].eb));
      tick();
    end
    load = 1'b0; clear = 1'b0;

    // Async reset in the middle of a clock low/high phase, no edge needed.
    fill();
    address = 3'd4;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", 32'(out), 32'h0);
    chk("async_rst_valid", 32'(valid), 32'h0);
    chk("async_rst_busy", 32'(busy), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reset aborting a running clear sequence.
    fill();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick(); tick(); tick();
    address = 3'd7;
    #1;
    chk("mid_clear_busy_pre", 32'(busy), 32'h1);
    chk("mid_clear_valid_pre", 32'(valid), 32'hF8);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_clear_busy", 32'(busy), 32'h0);
    chk("mid_clear_valid", 32'(valid), 32'h0);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      chk($sformatf("mid_clear_word%0d", a), 32'(out), 32'h0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    load = 1'b1; address = 3'd6; in = 16'h00AA;
    tick();
    load = 1'b0;
    #1;
    chk("post_rst_out6", 32'(out), 32'h00AA);
    chk("post_rst_valid", 32'(valid), 32'h40);

    // Held clear: two back-to-back sequences separated by one idle cycle.
    fill();
    clear = 1'b1;
    for (int n = 0; n < 22; n++) begin
      if (n == 17) clear = 1'b0;
      tick();
      eb = (n <= 7) || (n >= 9 && n <= 16);
      chk($sformatf("held_busy_e%0d", n), 32'(busy), 32'(eb));
    end
    chk("held_valid", 32'(valid), 32'h0);
    for (int a = 0; a < 8; a++) begin
      address = 3'(a);
      #1;
      chk($sformatf("held_word%0d", a), 32'(out), 32'h0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
